// File: rtl/rb_write_ctrl.sv
// -----------------------------------------------------------------------------
// rb_write_ctrl
//
// Write/read controller for the row buffers that feed the row-buffer steering
// stage. Each accepted raster pixel is written into the BRAM lane that holds
// the oldest row. In the same cycle all lanes are read at that column. The
// BRAM is read-first, so the read returns the previous RBs rows before the
// overwrite. One cycle later, matching the BRAM read latency, the controller
// drives steer_en/steer_sel so the steered window comes out oldest row first.
// It also presents the delayed pixel, its column, the primed flag and an
// end-of-frame pulse.
//
// Handshake: a pixel transfers in any cycle where in_valid && in_ready.
// in_ready is 1 in every cycle after reset and there is no backpressure.
// in_valid is sampled only together with in_ready. in_sof and in_pixel only
// mean something on a transfer.
//
// Optional feature:
//   RB_PRIME_GATE_EN  when defined, out_valid is also gated by the primed
//                     state, so no window leaves until RBs full rows of the
//                     current frame are stored. When undefined, every accept
//                     gives a window and downstream qualifies it with
//                     out_primed.
//
// Ports:
//   clk, rst_n          clock (rising edge); asynchronous active-low reset
//   in_valid/in_ready   pixel stream handshake
//   in_pixel            pixel data
//   in_sof              start of frame; resynchronises all counters
//   bram_we             one-hot write lane enable (combinational)
//   bram_waddr/wdata    write column and data (combinational)
//   bram_re/raddr       read enable and column for all lanes (combinational)
//   steer_en/steer_sel  steering enable and rotation; registered, aligned
//                       with the BRAM read data
//   out_valid           window column valid, aligned with the BRAM read data
//   out_pixel/out_col   accepted pixel and its column, delayed one cycle
//   out_primed          all lanes hold real rows of the current frame
//   frame_done          one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module rb_write_ctrl #(
  parameter int PIXEL_WIDTH       = 8,
  parameter int RBs               = 3,
  parameter int RB_ADDR           = 2,
  parameter int BRAM_R_DATA_WIDTH = 24,
  parameter int IMG_WIDTH         = 640,
  parameter int IMG_HEIGHT        = 480,
  parameter int COL_ADDR          = 10,
  parameter int ROW_ADDR          = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  input  logic                   in_sof,
  output logic [RBs-1:0]         bram_we,
  output logic [COL_ADDR-1:0]    bram_waddr,
  output logic [PIXEL_WIDTH-1:0] bram_wdata,
  output logic                   bram_re,
  output logic [COL_ADDR-1:0]    bram_raddr,
  output logic                   steer_en,
  output logic [RB_ADDR-1:0]     steer_sel,
  output logic                   out_valid,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic [COL_ADDR-1:0]    out_col,
  output logic                   out_primed,
  output logic                   frame_done
);

  // rows_filled has to hold the value RBs itself. That does not fit in
  // RB_ADDR bits when RBs is a power of two, so it gets its own width.
  localparam int FILL_W = $clog2(RBs + 1);

  localparam logic [COL_ADDR-1:0] COL_LAST  = COL_ADDR'(IMG_WIDTH - 1);
  localparam logic [ROW_ADDR-1:0] ROW_LAST  = ROW_ADDR'(IMG_HEIGHT - 1);
  localparam logic [RB_ADDR-1:0]  LANE_LAST = RB_ADDR'(RBs - 1);
  localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(RBs);
  localparam logic [FILL_W-1:0]   FILL_LAST = FILL_W'(RBs - 1);
  localparam logic [RBs-1:0]      LANE0_OH  = RBs'(1);

  // The read bus carries one pixel per lane. A mismatched parameter set
  // would silently misalign the steering stage.
  if (BRAM_R_DATA_WIDTH != RBs * PIXEL_WIDTH) begin : g_bad_cfg
    $error("rb_write_ctrl: BRAM_R_DATA_WIDTH must equal RBs*PIXEL_WIDTH");
  end

  // PRIME: fewer than RBs rows of this frame stored. STREAM: window complete.
  typedef enum logic {
    ST_PRIME  = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t state_q, state_d, state_eff;

  logic [COL_ADDR-1:0] col_q, col_d, col_eff;
  logic [ROW_ADDR-1:0] row_q, row_d, row_eff;
  logic [RB_ADDR-1:0]  wr_ptr_q, wr_ptr_d, wr_ptr_eff;
  logic [FILL_W-1:0]   rows_filled_q, rows_filled_d, rows_filled_eff;

  logic ready_q;
  logic accept;
  logic sof_acc;
  logic end_row;
  logic end_frame;

  assign in_ready = ready_q;
  assign accept   = in_valid && ready_q;
  assign sof_acc  = accept && in_sof;

  // An accepted start-of-frame zeroes the position before this pixel is
  // handled. The pixel lands in lane 0, column 0, whatever came before.
  always_comb begin
    col_eff         = col_q;
    row_eff         = row_q;
    wr_ptr_eff      = wr_ptr_q;
    rows_filled_eff = rows_filled_q;
    state_eff       = state_q;
    if (sof_acc) begin
      col_eff         = '0;
      row_eff         = '0;
      wr_ptr_eff      = '0;
      rows_filled_eff = '0;
      state_eff       = ST_PRIME;
    end
  end

  assign end_row   = accept && (col_eff == COL_LAST);
  assign end_frame = end_row && (row_eff == ROW_LAST);

  // ---------------------------------------------------------------------------
  // BRAM strobes: combinational in the accept cycle. The write and the
  // read-first read share one column, so the read returns the RBs older rows
  // at that column, including the row being overwritten.
  // ---------------------------------------------------------------------------
  always_comb begin
    bram_we    = '0;
    bram_waddr = '0;
    bram_wdata = '0;
    bram_re    = 1'b0;
    bram_raddr = '0;
    if (accept) begin
      bram_we    = LANE0_OH << wr_ptr_eff;
      bram_waddr = col_eff;
      bram_wdata = in_pixel;
      bram_re    = 1'b1;
      bram_raddr = col_eff;
    end
  end

  // ---------------------------------------------------------------------------
  // Position counters: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    wr_ptr_d      = wr_ptr_q;
    rows_filled_d = rows_filled_q;
    if (accept) begin
      col_d         = col_eff + 1'b1;
      row_d         = row_eff;
      wr_ptr_d      = wr_ptr_eff;
      rows_filled_d = rows_filled_eff;
      if (end_row) begin
        col_d = '0;
        if (end_frame) begin
          row_d         = '0;
          wr_ptr_d      = '0;
          rows_filled_d = '0;
        end else begin
          row_d    = row_eff + 1'b1;
          // Lane count need not be a power of two, so wrap explicitly.
          wr_ptr_d = (wr_ptr_eff == LANE_LAST) ? '0 : wr_ptr_eff + 1'b1;
          if (rows_filled_eff != FILL_FULL) begin
            rows_filled_d = rows_filled_eff + 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Priming FSM: next-state logic. The state tracks rows_filled == RBs. It
  // moves to STREAM when the row that fills the last lane completes. It drops
  // back to PRIME at frame end or on an accepted start-of-frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = state_eff;
      if (end_frame) begin
        state_d = ST_PRIME;
      end else if (end_row && (rows_filled_eff == FILL_LAST)) begin
        state_d = ST_STREAM;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PRIME;
      col_q         <= '0;
      row_q         <= '0;
      wr_ptr_q      <= '0;
      rows_filled_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      wr_ptr_q      <= wr_ptr_d;
      rows_filled_q <= rows_filled_d;
      ready_q       <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Aligned outputs: one cycle after the accept, matching BRAM read latency.
  // steer_sel is the lane written in the accept cycle. That lane held the
  // oldest row before the write, so rotating by it orders the window oldest
  // to newest. out_pixel/out_col hold their last value between accepts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steer_en   <= 1'b0;
      steer_sel  <= '0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_col    <= '0;
      out_primed <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      steer_en   <= accept;
`ifdef RB_PRIME_GATE_EN
      // Primed is judged before this accept's row completes. The window read
      // in this cycle only holds real data if RBs rows were already stored.
      out_valid  <= accept && (state_eff == ST_STREAM);
`else
      out_valid  <= accept;
`endif
      out_primed <= (state_d == ST_STREAM);
      frame_done <= end_frame;
      if (accept) begin
        steer_sel <= wr_ptr_eff;
        out_pixel <= in_pixel;
        out_col   <= col_eff;
      end
    end
  end

endmodule

// File: tb/tb_rb_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rb_write_ctrl
//
// Small-image bench for rb_write_ctrl: RBs=3, a 4x5 frame. A read-first BRAM
// model sits on the strobes, so the bench can check that the rotated read
// data gives the RBs previous rows at the current column. The reference
// model keeps only the linear pixel index within the frame and derives
// column, row, lane and primed state from it arithmetically.
// -----------------------------------------------------------------------------
module tb_rb_write_ctrl;

  localparam int PW  = 8;
  localparam int RBS = 3;
  localparam int RBA = 2;
  localparam int W   = 4;
  localparam int H   = 5;
  localparam int CA  = 2;
  localparam int RA  = 3;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [PW-1:0]  in_pixel;
  logic           in_sof;
  logic [RBS-1:0] bram_we;
  logic [CA-1:0]  bram_waddr;
  logic [PW-1:0]  bram_wdata;
  logic           bram_re;
  logic [CA-1:0]  bram_raddr;
  logic           steer_en;
  logic [RBA-1:0] steer_sel;
  logic           out_valid;
  logic [PW-1:0]  out_pixel;
  logic [CA-1:0]  out_col;
  logic           out_primed;
  logic           frame_done;

  rb_write_ctrl #(
    .PIXEL_WIDTH      (PW),
    .RBs              (RBS),
    .RB_ADDR          (RBA),
    .BRAM_R_DATA_WIDTH(RBS * PW),
    .IMG_WIDTH        (W),
    .IMG_HEIGHT       (H),
    .COL_ADDR         (CA),
    .ROW_ADDR         (RA)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_sof    (in_sof),
    .bram_we   (bram_we),
    .bram_waddr(bram_waddr),
    .bram_wdata(bram_wdata),
    .bram_re   (bram_re),
    .bram_raddr(bram_raddr),
    .steer_en  (steer_en),
    .steer_sel (steer_sel),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .out_col   (out_col),
    .out_primed(out_primed),
    .frame_done(frame_done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Read-first BRAM model, one lane per row buffer
  logic [PW-1:0] mem   [RBS][W];
  logic [PW-1:0] rdata [RBS];

  always @(posedge clk) begin
    for (int k = 0; k < RBS; k++) begin
      if (bram_re) rdata[k] <= mem[k][bram_raddr];
      if (bram_we[k]) mem[k][bram_waddr] <= bram_wdata;
    end
  end

  // Scoreboard state
  int checks;
  int failures;
  int p;              // pixel index within the current frame
  int hist [H][W];    // pixels of the current frame by row/column

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit gate_ok(input int row);
`ifdef RB_PRIME_GATE_EN
    return row >= RBS;
`else
    return (row >= 0);
`endif
  endfunction

  // One clock cycle. Called at a falling edge and returns at the next one.
  task automatic step(input bit v, input bit s, input logic [PW-1:0] pix);
    int pe, r, c, np;
    bit last;
    in_valid = v;
    in_sof   = s;
    in_pixel = pix;
    #1;
    pe = (v && s) ? 0 : p;
    r  = pe / W;
    c  = pe % W;
    if (v) begin
      chk("bram_we",    32'(bram_we),    32'(1 << (r % RBS)));
      chk("bram_waddr", 32'(bram_waddr), 32'(c));
      chk("bram_raddr", 32'(bram_raddr), 32'(c));
      chk("bram_re",    32'(bram_re),    32'd1);
      chk("bram_wdata", 32'(bram_wdata), 32'(pix));
    end else begin
      chk("bram_we_idle", 32'(bram_we), 32'd0);
      chk("bram_re_idle", 32'(bram_re), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    if (v) begin
      last = (pe == W * H - 1);
      np   = last ? 0 : pe + 1;
      hist[r][c] = int'(pix);
      chk("steer_en",   32'(steer_en),   32'd1);
      chk("steer_sel",  32'(steer_sel),  32'(r % RBS));
      chk("out_col",    32'(out_col),    32'(c));
      chk("out_pixel",  32'(out_pixel),  32'(pix));
      chk("out_valid",  32'(out_valid),  32'(gate_ok(r)));
      chk("frame_done", 32'(frame_done), 32'(last));
      if (r >= RBS) begin
        for (int j = 0; j < RBS; j++) begin
          chk("window", 32'(rdata[(r % RBS + j) % RBS]), 32'(hist[r - RBS + j][c]));
        end
      end
      p = np;
    end else begin
      chk("steer_en_idle",   32'(steer_en),   32'd0);
      chk("out_valid_idle",  32'(out_valid),  32'd0);
      chk("frame_done_idle", 32'(frame_done), 32'd0);
    end
    chk("out_primed", 32'(out_primed), 32'((p / W) >= RBS));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd0);
    chk({tag, "_bram_we"},    32'(bram_we),    32'd0);
    chk({tag, "_bram_re"},    32'(bram_re),    32'd0);
    chk({tag, "_steer_en"},   32'(steer_en),   32'd0);
    chk({tag, "_steer_sel"},  32'(steer_sel),  32'd0);
    chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
    chk({tag, "_out_pixel"},  32'(out_pixel),  32'd0);
    chk({tag, "_out_col"},    32'(out_col),    32'd0);
    chk({tag, "_out_primed"}, 32'(out_primed), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    p        = 0;
    for (int k = 0; k < RBS; k++)
      for (int c = 0; c < W; c++) mem[k][c] = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;

    // Reset, then idle
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    step(1'b0, 1'b0, 8'h00);

    // Pixels 0..13: prime three rows, then the first window rows
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, PW'(i));
    // Row 3, column 1: lanes 0,1,2 hold rows 0,1,2, i.e. pixels 1,5,9
    chk("dir_lane0", 32'(rdata[0]), 32'd1);
    chk("dir_lane1", 32'(rdata[1]), 32'd5);
    chk("dir_lane2", 32'(rdata[2]), 32'd9);
    chk("dir_sel",   32'(steer_sel), 32'd0);
    chk("dir_pixel", 32'(out_pixel), 32'd13);
    // Rest of the frame: pixel 19 is the last one and triggers frame_done
    for (int i = 14; i < 20; i++) step(1'b1, 1'b0, PW'(i));
    chk("dir_frame_done", 32'(frame_done), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    chk("dir_frame_done_pulse", 32'(frame_done), 32'd0);

    // Gaps: valid 1,0,1
    step(1'b1, 1'b0, 8'hA0);
    step(1'b0, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hA2);

    // Move to column 2, lane 1 (pixel index 6), then start of frame mid-row
    while (p != 6) step(1'b1, 1'b0, 8'(p + 8'h30));
    step(1'b1, 1'b1, 8'h5A);

    // Randomized traffic with occasional start-of-frame
    for (int i = 0; i < 400; i++)
      step(1'(($urandom_range(0, 99) < 75)), 1'(($urandom_range(0, 99) < 3)), PW'($urandom));

    // Reset in the middle of a row
    while ((p % W) == 0) step(1'b1, 1'b0, PW'($urandom));
    step(1'b1, 1'b0, 8'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrow_reset");
    p = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rerst", 32'(in_ready), 32'd1);
    for (int i = 0; i < 60; i++)
      step(1'(($urandom_range(0, 99) < 80)), 1'b0, PW'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rb_write_ctrl.md
# rb_write_ctrl

Row-buffer write/read controller that sits directly upstream of the row-buffer steering stage in the neighbourhood-image-processing pipeline. It accepts a raster pixel stream, writes each pixel into the BRAM lane of the current (oldest) row buffer, and issues the matching column read of all row buffers. One BRAM read latency later it drives the steering stage's `en` and `sel` so the steered output is ordered oldest row to newest row. It also tracks column, row and priming state, and flags when a full `RBs`-row window is valid.

## Interface
Parameters (shared `par.vh` set):
- `PIXEL_WIDTH`, 8: bits per pixel.
- `RBs`, 3: number of row buffers, which is also the BRAM lane count. Need not be a power of two.
- `RB_ADDR`, 2: width of the lane select, `clog2(RBs)`.
- `BRAM_R_DATA_WIDTH`, 24: `RBs*PIXEL_WIDTH`.
- `IMG_WIDTH`, 640: pixels per row.
- `IMG_HEIGHT`, 480: rows per frame.
- `COL_ADDR`, 10: `clog2(IMG_WIDTH)`.
- `ROW_ADDR`, 9: `clog2(IMG_HEIGHT)`.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: input pixel valid.
- `in_ready` out 1: controller can accept a pixel.
- `in_pixel` in PIXEL_WIDTH: input pixel.
- `in_sof` in 1: start of frame, qualified by an accepted pixel.
- `bram_we` out RBs: one-hot write lane enable.
- `bram_waddr` out COL_ADDR: write column.
- `bram_wdata` out PIXEL_WIDTH: write data.
- `bram_re` out 1: read enable.
- `bram_raddr` out COL_ADDR: read column.
- `steer_en` out 1: enable to the steering stage.
- `steer_sel` out RB_ADDR: rotation select, equal to the lane holding the oldest row.
- `out_valid` out 1: window column valid, aligned with BRAM read data.
- `out_pixel` out PIXEL_WIDTH: current pixel delayed to align with the window.
- `out_col` out COL_ADDR: column of the aligned window.
- `out_primed` out 1: all lanes hold real rows of the current frame.
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame.

## Operation
- Accept occurs when `in_valid && in_ready`. `in_ready` is 1 whenever out of reset; there is no downstream backpressure.
- On accept, write `in_pixel` into lane `wr_ptr` at address `col`. `bram_we` = one-hot(`wr_ptr`), `bram_waddr` = `col`.
- In the same cycle, read all lanes at `col`: `bram_re` = 1, `bram_raddr` = `col`. The BRAM is read-first, so the read returns the previous `RBs` rows.
- State `PRIME`: `rows_filled < RBs`. State `STREAM`: `rows_filled == RBs`. `out_primed` = (state == STREAM), registered with the other outputs.
- Counter update on each accept:
  - `col` increments.
  - At `col == IMG_WIDTH-1`: `col` goes to 0, `wr_ptr` goes to (`wr_ptr == RBs-1`) ? 0 : `wr_ptr+1`, `row` increments, and `rows_filled` increments, saturating at `RBs`.
  - At end of row with `row == IMG_HEIGHT-1`: `row`, `wr_ptr` and `rows_filled` go to 0, the state goes to PRIME, and `frame_done` pulses next cycle.
- `in_sof` on an accepted pixel forces `col`, `row`, `wr_ptr` and `rows_filled` to 0 before that pixel is processed. The pixel is written at lane 0, column 0. This resynchronises after a truncated frame.
- With no accept, BRAM enables are 0 and all counters hold.

## Timing
- Reset values: all outputs 0. `wr_ptr`, `col`, `row` and `rows_filled` are 0. State is PRIME.
- Reset mid-row discards all counter state. BRAM contents are not cleared; priming re-gates them.
- The BRAM strobes (`bram_we`, `bram_waddr`, `bram_wdata`, `bram_re`, `bram_raddr`) are combinational from the accept and the counters, in cycle t.
- In cycle t+1 (registered):
  - `steer_en` = 1 and `steer_sel` = `wr_ptr` value from cycle t.
  - `out_pixel` and `out_col` are the values from cycle t.
  - `out_valid` per Configuration.
- Latency from accept to aligned window is exactly 1 cycle. Back-to-back accepts give one window per cycle.
- `steer_en` is 0 in any cycle after a non-accept cycle.

## Configuration
- `RB_PRIME_GATE_EN` defined: `out_valid` = previous-cycle accept AND primed. No window leaves until `RBs` full rows are stored.
- `RB_PRIME_GATE_EN` undefined: `out_valid` = previous-cycle accept. Lanes not yet filled in the current frame carry stale data, and downstream must qualify with `out_primed`.

## Test plan
- Reset then idle: all outputs 0. `in_ready` = 1 after `rst_n` rises.
- `RBs=3`, `IMG_WIDTH=4`: stream 12 pixels with values 0..11.
  - Writes go to lane 0 (cols 0-3), then lane 1, then lane 2.
  - `steer_sel` follows 0,0,0,0,1,1,1,1,2,2,2,2, lagging by one cycle.
  - With gating, `out_valid` stays 0 for the first 12 accepts. The 13th accept gives `out_valid`=1 with `steer_sel`=0.
- Continue the stream to row 4: `wr_ptr` wraps from 2 to 0.
  - The window at col 1 reads lanes {0,1,2} = {1,5,9} before overwrite.
  - `out_pixel` = 13.
- `IMG_HEIGHT=5`: after 20 accepts, `frame_done` pulses for 1 cycle. Counters and `out_primed` return to 0.
- `in_sof` asserted on an accept mid-row (col 2, `wr_ptr` 1): the pixel is written to lane 0, col 0, and `out_col`=0 next cycle.
- Gaps: `in_valid` toggling 1,0,1 gives `steer_en`/`out_valid` of 1,0,1, and counters advance only on accepts. Assert `rst_n` low mid-row: outputs go to 0 immediately.
